// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants and types.
package ntt_pkg;

    // Coefficient width and the NTT-friendly prime 2^28 - 2^16 + 1.
    localparam int unsigned COEF_W = 28;
    localparam int unsigned Q      = 32'd268369921;

    typedef logic [COEF_W-1:0] coef_t;

    // Read-side FSM of the inter-stage shuffle buffer.
    typedef enum logic [0:0] {
        StIdle,
        StRead
    } rd_state_e;

endpackage

// File: rtl/ntt_stage_shuffle_bank.sv
// M-word register array: one synchronous write port, two combinational read ports.
module shuffle_bank
    import ntt_pkg::*;
#(
    parameter int unsigned LOG_DEPTH = 4,
    parameter int unsigned W         = COEF_W
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [LOG_DEPTH-1:0] waddr,
    input  logic [W-1:0]         wdata,
    input  logic [LOG_DEPTH-1:0] raddr_a,
    output logic [W-1:0]         rdata_a,
    input  logic [LOG_DEPTH-1:0] raddr_b,
    output logic [W-1:0]         rdata_b
);

    localparam int unsigned Depth = 1 << LOG_DEPTH;

    // Storage is not reset; contents are don't-care until written.
    logic [W-1:0] mem_q [Depth];

    // Single write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/ntt_stage_shuffle.sv
// Ping-pong reorder buffer: takes (x,y) pairs at butterfly distance M and
// re-emits the same block paired at distance M/2 for the next stage.
module ntt_stage_shuffle
    import ntt_pkg::*;
#(
    parameter int unsigned LOG_M = 4,
    parameter int unsigned W     = COEF_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     x_in,
    input  logic [W-1:0]     y_in,
    output logic             out_valid,
    output logic [W-1:0]     x_out,
    output logic [W-1:0]     y_out,
    output logic [LOG_M-1:0] out_idx,
    output logic             out_last
);

    localparam int unsigned      M       = 1 << LOG_M;
    localparam logic [LOG_M-1:0] LastIdx = LOG_M'(M - 1);
    // Set in an address, this bit selects the upper half (offset M/2) of a bank.
    localparam logic [LOG_M-1:0] HalfBit = LOG_M'(M / 2);

    // Write side
    logic [LOG_M-1:0] wr_k_q;
    logic             wp_q;
    logic             page_full;

    // Read side
    rd_state_e        state_q, state_d;
    logic [LOG_M-1:0] rd_j_q, rd_j_d;
    logic             rd_page_q, rd_page_d;
    logic             pending_q, pending_d;
    logic             emit;

    logic [LOG_M-1:0] rd_lo;
    logic [LOG_M-1:0] rd_hi;
    logic             rd_g;
    logic [W-1:0]     rd_x;
    logic [W-1:0]     rd_y;

    logic [1:0][W-1:0] x_lo;
    logic [1:0][W-1:0] x_hi;
    logic [1:0][W-1:0] y_lo;
    logic [1:0][W-1:0] y_hi;

    // The last pair of a block closes the page in the same cycle it is written.
    assign page_full = in_valid && (wr_k_q == LastIdx);

    // Write pointer and page toggle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_k_q <= '0;
            wp_q   <= 1'b0;
        end else if (in_valid) begin
            wr_k_q <= wr_k_q + LOG_M'(1);
            if (page_full) begin
                wp_q <= ~wp_q;
            end
        end
    end

    // Pair j reads word r and r+M/2 of the X bank (first half of j) or Y bank.
    assign rd_g  = rd_j_q[LOG_M-1];
    assign rd_lo = rd_j_q & ~HalfBit;
    assign rd_hi = rd_j_q | HalfBit;

    // Two pages, each with an X bank (e[0..M-1]) and a Y bank (e[M..2M-1]).
    for (genvar p = 0; p < 2; p++) begin : g_page
        logic we;
        assign we = in_valid && (wp_q == 1'(p));

        shuffle_bank #(
            .LOG_DEPTH (LOG_M),
            .W         (W)
        ) u_x_bank (
            .clk     (clk),
            .we      (we),
            .waddr   (wr_k_q),
            .wdata   (x_in),
            .raddr_a (rd_lo),
            .rdata_a (x_lo[p]),
            .raddr_b (rd_hi),
            .rdata_b (x_hi[p])
        );

        shuffle_bank #(
            .LOG_DEPTH (LOG_M),
            .W         (W)
        ) u_y_bank (
            .clk     (clk),
            .we      (we),
            .waddr   (wr_k_q),
            .wdata   (y_in),
            .raddr_a (rd_lo),
            .rdata_a (y_lo[p]),
            .raddr_b (rd_hi),
            .rdata_b (y_hi[p])
        );
    end

    assign rd_x = rd_g ? y_lo[rd_page_q] : x_lo[rd_page_q];
    assign rd_y = rd_g ? y_hi[rd_page_q] : x_hi[rd_page_q];

    // Read FSM next-state: drain a page, chaining straight into the other page if full.
    always_comb begin
        state_d   = state_q;
        rd_j_d    = rd_j_q;
        rd_page_d = rd_page_q;
        pending_d = pending_q;
        emit      = 1'b0;
        case (state_q)
            StIdle: begin
                if (page_full) begin
                    state_d   = StRead;
                    rd_j_d    = '0;
                    rd_page_d = wp_q;
                end
            end
            StRead: begin
                emit = 1'b1;
                if (rd_j_q == LastIdx) begin
                    // Next full page is always the other one.
                    if (pending_q || page_full) begin
                        rd_j_d    = '0;
                        rd_page_d = ~rd_page_q;
                        pending_d = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    rd_j_d = rd_j_q + LOG_M'(1);
                    if (page_full) begin
                        pending_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            rd_j_q    <= '0;
            rd_page_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_j_q    <= rd_j_d;
            rd_page_q <= rd_page_d;
            pending_q <= pending_d;
        end
    end

    // Registered outputs; data and index hold while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            x_out     <= '0;
            y_out     <= '0;
        end else begin
            out_valid <= emit;
            out_last  <= emit && (rd_j_q == LastIdx);
            if (emit) begin
                x_out   <= rd_x;
                y_out   <= rd_y;
                out_idx <= rd_j_q;
            end
        end
    end

    // Input rate never exceeds drain rate, so a second pending page is impossible.
    a_no_double_pending : assert property (@(posedge clk) disable iff (!rst)
        !(page_full && pending_q));

    // A page is never rewritten while it is still being read.
    a_no_page_overlap : assert property (@(posedge clk) disable iff (!rst)
        !(state_q == StRead && in_valid && wp_q == rd_page_q));

endmodule

// File: doc/ntt_stage_shuffle.md
Name: ntt_stage_shuffle

Overview:
- Inter-stage reorder buffer placed directly downstream of one butterfly lane and upstream of the next-stage butterfly.
- Consumes the (x,y) pair stream produced at butterfly distance M and re-emits the same coefficients paired at distance M/2, which the next Cooley-Tukey stage needs.
- Double-buffered (ping-pong), so a continuous input stream gives a continuous output stream with no bubbles.

Parameters:
- LOG_M, 4: log2 of pairs per block. M = 2^LOG_M pairs = 2M coefficients per block. Legal range 1..8.
- W, 28: coefficient width (ntt_pkg::COEF_W).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  input pair present this cycle; no backpressure
- x_in  in  W  element e[k] of input pair k
- y_in  in  W  element e[k+M] of input pair k
- out_valid  out  1  output pair valid
- x_out  out  W  output x element
- y_out  out  W  output y element
- out_idx  out  LOG_M  index j of the current output pair within its block
- out_last  out  1  high with output pair j = M-1

Behaviour:
- Reset (rst low, async): out_valid=0, out_last=0, out_idx=0, x_out=0, y_out=0. Write pointer, write page and read state are cleared. Storage contents are don't-care.
- Storage: two pages. Each page has an X bank (e[0..M-1]) and a Y bank (e[M..2M-1]), M words each.
- Write side:
  - On each in_valid, store x_in to X[wp][k] and y_in to Y[wp][k], then increment k.
  - When k wraps from M-1 to 0, toggle wp and raise a one-cycle page_full event for the filled page.
  - Gaps in in_valid only stall k. They do not corrupt ordering.
- Read FSM states:
  - IDLE: page_full moves to READ with j=0 on the next cycle.
  - READ: emit one pair per cycle for j = 0..M-1. At j=M-1, if another page_full is pending, continue in READ on the other page with j=0 and no bubble. Otherwise return to IDLE.
- Output mapping for pair j: g = j >> (LOG_M-1), r = j mod M/2.
  - g=0: x = X[r], y = X[r+M/2].
  - g=1: x = Y[r], y = Y[r+M/2].
- Outputs are registered.
- Latency: if the last input pair of a block is sampled at edge t, output pair 0 appears (out_valid=1) after edge t+1. Pairs j follow on consecutive edges.
- out_idx = j. out_last = (j == M-1) and out_valid.
- Page conflict: since input is at most 1 pair/cycle and output drains at exactly 1/cycle, a page always finishes reading before it is rewritten. page_full arriving while in READ is latched as pending (one-deep). The case of a second page_full while pending is already set cannot occur and is flagged by an assertion.
- Simultaneous events: a write to page wp and a read of page ~wp in the same cycle are independent.
- A page_full coinciding with j=M-1 chains without a bubble.
- Reset mid-block: the partial input block and any in-flight output are discarded. The first block after reset starts at k=0.
- When out_valid=0, x_out and y_out hold their last values.

Decomposition:
- ntt_pkg:
  - COEF_W = 28
  - Q = 2^28 - 2^16 + 1
  - typedef coef_t = logic [COEF_W-1:0]
- One sub-module: shuffle_bank (M-word register array with one write port and two combinational read ports). Instantiated four times: X/Y × two pages.
- The FSM and pointers live in the top module.

Test Plan (LOG_M=4, M=16):
1. Single block: feed pairs k=0..15 back-to-back, with x=k, y=k+16 (a "block" means k=0..15 sent this way). After the edge following k=15, expect 16 consecutive outputs: j=0 (0,8), j=7 (7,15), j=8 (16,24), j=15 (23,31). out_last is high only at j=15, and out_valid drops afterwards.
2. Continuous stream: feed 4 blocks back-to-back, each block with values offset by 100·b. Expect 64 consecutive out_valid cycles with no gap, correct per-block mapping, and out_idx cycling 0..15 four times.
3. Gappy input: assert in_valid every third cycle for one block. Expect output identical to scenario 1, with output beginning one edge after the 16th valid input.
4. Reset mid-operation: pull rst low asynchronously after 9 input pairs, release, then send one full block. Expect outputs to drop to 0 immediately on reset, and only the post-reset block to be emitted, mapped correctly.
5. Reset during output: pull rst low at output j=5. Expect out_valid=0 at once and no further outputs until a new full block arrives.
6. Edge parameter LOG_M=1: send pairs (1,3),(2,4). Expect outputs (1,2) then (3,4), with out_last on the second.
